// File: rtl/voxel_score_engine_if.sv
// Request/result and memory-read bundle between the voxel classifier controller
// and the score engine; the engine takes the slave modport.
interface voxel_score_engine_if #(
    parameter int unsigned NUM_CLASSES = 4,
    parameter int unsigned NUM_CELLS   = 1024,
    parameter int unsigned WEIGHT_BITS = 8,
    parameter int unsigned COUNT_BITS  = 8,
    parameter int unsigned ACC_BITS    = 24
);
    localparam int unsigned ADDR_BITS  = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam int unsigned CLASS_BITS = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    logic                            start;
    logic                            busy;
    logic [ADDR_BITS-1:0]            cell_addr;
    logic [NUM_CLASSES*WEIGHT_BITS-1:0] weight_in;
    logic [COUNT_BITS-1:0]           count_in;
    logic [NUM_CLASSES*ACC_BITS-1:0] scores;
    logic [CLASS_BITS-1:0]           best_class;
    logic [ACC_BITS-1:0]             best_score;
    logic                            done;
    logic                            confident;

    modport master (
        output start, weight_in, count_in,
        input  busy, cell_addr, scores, best_class, best_score, done, confident
    );

    modport slave (
        input  start, weight_in, count_in,
        output busy, cell_addr, scores, best_class, best_score, done, confident
    );
endinterface

// File: rtl/voxel_score_engine.sv
// Sweeps all cells once, MACs signed weight x count per class with saturation, then argmax.
// Optional SCORE_CONF_THRESH_EN: confident compares best_score against CONF_THRESH.
module voxel_score_engine #(
    parameter int unsigned NUM_CLASSES = 4,
    parameter int unsigned NUM_CELLS   = 1024,
    parameter int unsigned WEIGHT_BITS = 8,
    parameter int unsigned COUNT_BITS  = 8,
    parameter int unsigned ACC_BITS    = 24,
    parameter int          CONF_THRESH = 64
) (
    input logic clk,
    input logic rst,
    voxel_score_engine_if.slave bus
);
    localparam int unsigned ADDR_BITS  = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam int unsigned CLASS_BITS = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int unsigned PROD_BITS  = WEIGHT_BITS + COUNT_BITS + 1;
    localparam int unsigned SUM_BITS   = ((ACC_BITS > PROD_BITS) ? ACC_BITS : PROD_BITS) + 1;
    localparam logic signed [SUM_BITS-1:0] SAT_HI = (SUM_BITS'(1) <<< (ACC_BITS - 1)) - 1;
    localparam logic signed [SUM_BITS-1:0] SAT_LO = -(SUM_BITS'(1) <<< (ACC_BITS - 1));

    typedef enum logic [2:0] {StIdle, StSweep, StDrain, StArgmax, StDone} state_e;

    state_e                      state_q;
    logic [ADDR_BITS-1:0]        addr_q;
    logic [1:0]                  vld_q;  // [0]: address issued, [1]: read data present
    logic signed [ACC_BITS-1:0]  acc_q [NUM_CLASSES];
    logic [CLASS_BITS-1:0]       arg_idx_q;
    logic [CLASS_BITS-1:0]       best_idx_q;
    logic signed [ACC_BITS-1:0]  best_val_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        conf_q;
    logic [CLASS_BITS-1:0]       best_class_q;
    logic [ACC_BITS-1:0]         best_score_q;
    logic [NUM_CLASSES*ACC_BITS-1:0] scores_q;

    logic signed [WEIGHT_BITS-1:0] w     [NUM_CLASSES];
    logic signed [COUNT_BITS:0]    cnt;
    logic signed [PROD_BITS-1:0]   prod  [NUM_CLASSES];
    logic signed [SUM_BITS-1:0]    sum   [NUM_CLASSES];
    logic signed [ACC_BITS-1:0]    acc_d [NUM_CLASSES];
    logic [NUM_CLASSES*ACC_BITS-1:0] acc_flat;

    always_comb begin
        cnt = $signed({1'b0, bus.count_in});
        acc_flat = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            w[c]    = $signed(bus.weight_in[c*WEIGHT_BITS +: WEIGHT_BITS]);
            prod[c] = PROD_BITS'(w[c]) * PROD_BITS'(cnt);
            sum[c]  = SUM_BITS'(acc_q[c]) + SUM_BITS'(prod[c]);
            if (sum[c] > SAT_HI) begin
                acc_d[c] = SAT_HI[ACC_BITS-1:0];
            end else if (sum[c] < SAT_LO) begin
                acc_d[c] = SAT_LO[ACC_BITS-1:0];
            end else begin
                acc_d[c] = sum[c][ACC_BITS-1:0];
            end
            acc_flat[c*ACC_BITS +: ACC_BITS] = acc_q[c];
        end
    end

    // Class 0 seeds the running best; later classes win only when strictly greater.
    logic signed [ACC_BITS-1:0] cand;
    logic                       take;
    logic signed [ACC_BITS-1:0] best_val_d;
    logic [CLASS_BITS-1:0]      best_idx_d;
    logic                       conf_d;

    always_comb begin
        cand       = acc_q[arg_idx_q];
        take       = (arg_idx_q == '0) || (cand > best_val_q);
        best_val_d = take ? cand : best_val_q;
        best_idx_d = take ? arg_idx_q : best_idx_q;
`ifdef SCORE_CONF_THRESH_EN
        conf_d = (best_val_d >= $signed(ACC_BITS'(CONF_THRESH)));
`else
        conf_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            vld_q        <= '0;
            arg_idx_q    <= '0;
            best_idx_q   <= '0;
            best_val_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            conf_q       <= 1'b0;
            best_class_q <= '0;
            best_score_q <= '0;
            scores_q     <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) acc_q[c] <= '0;
        end else begin
            done_q <= 1'b0;
            vld_q  <= {vld_q[0], 1'b0};
            if (vld_q[1]) begin
                for (int c = 0; c < NUM_CLASSES; c++) acc_q[c] <= acc_d[c];
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q  <= StSweep;
                        addr_q   <= '0;
                        busy_q   <= 1'b1;
                        vld_q[0] <= 1'b1;
                        for (int c = 0; c < NUM_CLASSES; c++) acc_q[c] <= '0;
                    end
                end
                StSweep: begin
                    if (addr_q == ADDR_BITS'(NUM_CELLS - 1)) begin
                        state_q <= StDrain;
                    end else begin
                        addr_q   <= addr_q + 1'b1;
                        vld_q[0] <= 1'b1;
                    end
                end
                StDrain: begin
                    if (!vld_q[0]) begin
                        state_q   <= StArgmax;
                        arg_idx_q <= '0;
                    end
                end
                StArgmax: begin
                    best_val_q <= best_val_d;
                    best_idx_q <= best_idx_d;
                    if (arg_idx_q == CLASS_BITS'(NUM_CLASSES - 1)) begin
                        state_q      <= StDone;
                        done_q       <= 1'b1;
                        scores_q     <= acc_flat;
                        best_class_q <= best_idx_d;
                        best_score_q <= best_val_d;
                        conf_q       <= conf_d;
                    end else begin
                        arg_idx_q <= arg_idx_q + 1'b1;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.cell_addr  = addr_q;
    assign bus.scores     = scores_q;
    assign bus.best_class = best_class_q;
    assign bus.best_score = best_score_q;
    assign bus.done       = done_q;
    assign bus.confident  = conf_q;
endmodule
